onchip_memory_arbiter: RTL and testbench
========================================

# onchip_memory_arbiter

Two-port round-robin arbiter that shares the single-port 32-bit on-chip memory (14-bit word address, byte enables, one-cycle read latency) between two Avalon-MM masters, e.g. the Nios II data master (port 0) and the sudoku solver engine (port 1). It issues at most one command per clock to the memory and returns read data to the issuing port through `readdatavalid`. It keeps a lock for read-modify-write sequences and filters addresses beyond the populated depth.

## Interface
- `DEPTH`, 10024: populated words; addresses >= DEPTH are out of range.
- `AW`, 14: word address width.
- `clk`  in  1  single clock for all logic.
- `reset`  in  1  synchronous, active-high reset.
- `m0_address`, `m1_address`  in  AW  word address per port.
- `m0_byteenable`, `m1_byteenable`  in  4  byte lanes.
- `m0_read`, `m1_read`  in  1  read request.
- `m0_write`, `m1_write`  in  1  write request.
- `m0_writedata`, `m1_writedata`  in  32  write data.
- `m0_lock`, `m1_lock`  in  1  hold ownership after the current grant.
- `m0_waitrequest`, `m1_waitrequest`  out  1  command not accepted this cycle.
- `m0_readdata`, `m1_readdata`  out  32  read data.
- `m0_readdatavalid`, `m1_readdatavalid`  out  1  read data valid.
- `mem_address`  out  AW  to memory.
- `mem_byteenable`  out  4  to memory.
- `mem_chipselect`  out  1  to memory.
- `mem_write`  out  1  to memory.
- `mem_writedata`  out  32  to memory.
- `mem_clken`  out  1  to memory; tied to 1.
- `mem_readdata`  in  32  from memory, valid one cycle after the address edge.

## Operation
- Request on port i: `mi_read | mi_write`. Both read and write asserted together is illegal; the arbiter treats it as a write.
- Registered state:
  - `last`: 1 bit, port most recently granted.
  - `owner_locked`: 1 bit, plus the locked port id.
  - `rd_pend`: 1 bit, a read was issued last cycle.
  - `rd_port`: 1 bit, port that issued that read.
  - `rd_oor`: 1 bit, that read was out of range.
- Grant is combinational in the same cycle:
  - If locked, only the lock owner may be granted.
  - Otherwise, with a single requester, that requester wins.
  - With both requesting, the port != `last` wins.
- `mi_waitrequest = request_i & ~grant_i`. A port with no request sees waitrequest 0.
- Memory drive:
  - The granted port's address, byteenable and writedata go to the memory.
  - `mem_chipselect` = grant & in-range.
  - `mem_write` = granted write & in-range.
  - With no grant, `mem_chipselect` = 0 and `mem_write` = 0.
- Out-of-range writes are accepted with no waitrequest and discarded. Out-of-range reads are accepted and return 0x00000000.
- Lock:
  - When a granted command has `mi_lock` = 1, `owner_locked` is set to port i.
  - The lock clears at the first cycle where the owner has a granted command with lock = 0, or has no request and lock = 0.
  - While locked, the other port is stalled indefinitely. The master owns the responsibility for releasing the lock.
- Read return:
  - On a granted read, set `rd_pend`, `rd_port` and `rd_oor`.
  - Next cycle, `m<rd_port>_readdatavalid` = 1 and `readdata` = (`rd_oor` ? 0 : `mem_readdata`).
  - Both `mX_readdata` buses carry the same value; only `readdatavalid` is steered.
- `last` updates to the granted port on every grant.

## Timing
- Throughput: one command per cycle total. Back-to-back reads from the same or alternating ports are fully pipelined.
- Read latency: exactly 1 cycle from the accepted edge to the `readdatavalid` cycle; at most one read is outstanding.
- Write latency: 0. The memory is updated at the accept edge.
- A read issued in the cycle after a write to the same address returns the new data.
- Reset values, applied at the next `clk` edge while `reset` = 1:
  - `last` = 1, so port 0 wins the first tie.
  - Lock cleared, `rd_pend` = 0.
- Output behaviour while `reset` = 1:
  - Both `readdatavalid` = 0.
  - `mem_chipselect` = 0 and `mem_write` = 0.
  - Both waitrequest = 1 when requesting.
- Reset mid-read: a pending `readdatavalid` is dropped.

## Test plan
- Reset, then both ports read simultaneously (m0 @0x0010, m1 @0x0020, memory preloaded 0xAAAA0010 / 0xBBBB0020) -> cycle 0: m0 granted, m1_waitrequest = 1. Cycle 1: m0_readdatavalid with 0xAAAA0010, m1 granted. Cycle 2: m1_readdatavalid with 0xBBBB0020.
- Continuous requests on both ports for 8 cycles -> grants alternate 0,1,0,1…; each port gets exactly 4.
- m1 write 0x12345678, byteenable 0b0011 @0x0100 (old 0xFFFFFFFF), then m1 read @0x0100 the next cycle -> readdata 0xFFFF5678 one cycle later.
- m0 asserts lock on a read @0x0005, then a write @0x0005 with lock = 0, while m1 requests throughout -> m1 waitrequest = 1 for both cycles; m1 is granted in cycle 2.
- m1 read @10024 and write @12000 -> no `mem_chipselect`; readdatavalid next cycle with 0x00000000; memory contents unchanged.
- m0 read accepted, then `reset` asserted the following cycle -> no `m0_readdatavalid`. After release, `last` = 1 and port 0 wins the next tie.

Source files
------------

// File: rtl/onchip_memory_arbiter_if.sv
// Avalon-MM master-side bus for one arbiter port.
// The master modport drives commands; the slave modport returns stall and read data.
interface onchip_memory_arbiter_if #(
    parameter int AW = 14
);
    logic [AW-1:0] address;
    logic [3:0]    byteenable;
    logic          read;
    logic          write;
    logic [31:0]   writedata;
    logic          lock;
    logic          waitrequest;
    logic [31:0]   readdata;
    logic          readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata, lock,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata, lock,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/onchip_memory_arbiter.sv
// Two-port round-robin arbiter in front of a single-port, one-cycle-latency on-chip RAM.
// Supports a per-port lock for read-modify-write and drops accesses beyond DEPTH.
module onchip_memory_arbiter #(
    parameter int DEPTH = 10024,
    parameter int AW    = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    onchip_memory_arbiter_if.slave m0,
    onchip_memory_arbiter_if.slave m1,
    output logic [AW-1:0]         o_mem_address,
    output logic [3:0]            o_mem_byteenable,
    output logic                  o_mem_chipselect,
    output logic                  o_mem_write,
    output logic [31:0]           o_mem_writedata,
    output logic                  o_mem_clken,
    input  logic [31:0]           i_mem_readdata
);
    localparam logic [AW:0] LIM = DEPTH[AW:0];

    logic r_last;
    logic r_locked;
    logic r_lock_id;
    logic r_rd_pend;
    logic r_rd_port;
    logic r_rd_oor;

    logic          w_req0, w_req1;
    logic          w_gnt0, w_gnt1;
    logic          w_any, w_sel;
    logic [AW-1:0] w_addr;
    logic          w_wr;
    logic          w_lk;
    logic          w_inr;
    logic [31:0]   w_rdata;

    assign w_req0 = m0.read | m0.write;
    assign w_req1 = m1.read | m1.write;

    // Reset masks every grant so requesters see waitrequest while reset is held.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!reset) begin
            if (r_locked) begin
                w_gnt0 = ~r_lock_id & w_req0;
                w_gnt1 =  r_lock_id & w_req1;
            end else if (w_req0 && w_req1) begin
                w_gnt0 =  r_last;
                w_gnt1 = ~r_last;
            end else begin
                w_gnt0 = w_req0;
                w_gnt1 = w_req1;
            end
        end
    end

    assign w_any  = w_gnt0 | w_gnt1;
    assign w_sel  = w_gnt1;
    assign w_addr = w_sel ? m1.address : m0.address;
    // A simultaneous read+write is treated as a write.
    assign w_wr   = w_sel ? m1.write   : m0.write;
    assign w_lk   = w_sel ? m1.lock    : m0.lock;
    assign w_inr  = {1'b0, w_addr} < LIM;

    assign m0.waitrequest = w_req0 & ~w_gnt0;
    assign m1.waitrequest = w_req1 & ~w_gnt1;

    assign o_mem_address    = w_addr;
    assign o_mem_byteenable = w_sel ? m1.byteenable : m0.byteenable;
    assign o_mem_writedata  = w_sel ? m1.writedata  : m0.writedata;
    assign o_mem_chipselect = w_any & w_inr;
    assign o_mem_write      = w_any & w_wr & w_inr;
    assign o_mem_clken      = 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last    <= 1'b1;
            r_locked  <= 1'b0;
            r_lock_id <= 1'b0;
            r_rd_pend <= 1'b0;
            r_rd_port <= 1'b0;
            r_rd_oor  <= 1'b0;
        end else begin
            r_rd_pend <= w_any & ~w_wr;
            if (w_any) begin
                r_last    <= w_sel;
                r_rd_port <= w_sel;
                r_rd_oor  <= ~w_inr;
            end
            // Owner is always granted when requesting, so its lock input alone decides release.
            if (r_locked) begin
                r_locked <= r_lock_id ? m1.lock : m0.lock;
            end else if (w_any) begin
                r_locked  <= w_lk;
                r_lock_id <= w_sel;
            end
        end
    end

    assign w_rdata          = r_rd_oor ? 32'h0 : i_mem_readdata;
    assign m0.readdata      = w_rdata;
    assign m1.readdata      = w_rdata;
    assign m0.readdatavalid = r_rd_pend & ~r_rd_port & ~reset;
    assign m1.readdatavalid = r_rd_pend &  r_rd_port & ~reset;
endmodule

// File: tb/tb_onchip_memory_arbiter.sv
// Directed bench for onchip_memory_arbiter with a behavioural RAM and a read-return scoreboard.
module tb_onchip_memory_arbiter;
    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] mem_address;
    logic [3:0]    mem_byteenable;
    logic          mem_chipselect;
    logic          mem_write;
    logic [31:0]   mem_writedata;
    logic          mem_clken;
    logic [31:0]   mem_readdata = 32'h0;

    onchip_memory_arbiter_if #(.AW(AW)) m0_if ();
    onchip_memory_arbiter_if #(.AW(AW)) m1_if ();

    onchip_memory_arbiter #(.DEPTH(10024), .AW(AW)) dut (
        .clk              (clk),
        .reset            (reset),
        .m0               (m0_if.slave),
        .m1               (m1_if.slave),
        .o_mem_address    (mem_address),
        .o_mem_byteenable (mem_byteenable),
        .o_mem_chipselect (mem_chipselect),
        .o_mem_write      (mem_write),
        .o_mem_writedata  (mem_writedata),
        .o_mem_clken      (mem_clken),
        .i_mem_readdata   (mem_readdata)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM, preloaded on the first edge.
    bit [31:0] mem [0:16383];
    bit        init_done = 1'b0;
    always @(posedge clk) begin
        if (!init_done) begin
            mem[14'h0010] <= 32'hAAAA0010;
            mem[14'h0020] <= 32'hBBBB0020;
            mem[14'h0100] <= 32'hFFFFFFFF;
            mem[14'h0005] <= 32'h55555555;
            init_done     <= 1'b1;
        end else if (mem_chipselect && mem_clken) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) mem[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
            end else begin
                mem_readdata <= mem[mem_address];
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        port;
        logic [31:0] data;
    } exp_t;
    exp_t q[$];

    task automatic push(input logic port, input logic [31:0] data);
        exp_t e;
        e.port = port;
        e.data = data;
        q.push_back(e);
    endtask

    // Monitor: every readdatavalid pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (m0_if.readdatavalid || m1_if.readdatavalid) begin
            if (m0_if.readdatavalid && m1_if.readdatavalid) begin
                chk("rdv_onehot", {30'h0, m1_if.readdatavalid, m0_if.readdatavalid}, 32'h1);
            end else if (q.size() == 0) begin
                chk("rdv_unexpected", {30'h0, m1_if.readdatavalid, m0_if.readdatavalid}, 32'h0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rd_port", {31'h0, m1_if.readdatavalid}, {31'h0, e.port});
                chk("rd_data_m0", m0_if.readdata, e.data);
                chk("rd_data_m1", m1_if.readdata, e.data);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic p, input logic rd, input logic wr, input logic [AW-1:0] a,
                         input logic [31:0] d, input logic [3:0] be, input logic lk);
        if (!p) begin
            m0_if.read = rd; m0_if.write = wr; m0_if.address = a;
            m0_if.writedata = d; m0_if.byteenable = be; m0_if.lock = lk;
        end else begin
            m1_if.read = rd; m1_if.write = wr; m1_if.address = a;
            m1_if.writedata = d; m1_if.byteenable = be; m1_if.lock = lk;
        end
    endtask

    task automatic idle(input logic p);
        drive(p, 1'b0, 1'b0, '0, 32'h0, 4'h0, 1'b0);
    endtask

    int g0, g1;

    initial begin
        reset = 1'b1;
        idle(1'b0);
        idle(1'b1);
        drive(1'b0, 1'b1, 1'b0, 14'h0010, 32'h0, 4'hF, 1'b0);

        // Reset state while m0 requests
        @(negedge clk);
        chk("rst_m0_wait", {31'h0, m0_if.waitrequest}, 32'h1);
        chk("rst_cs", {31'h0, mem_chipselect}, 32'h0);
        chk("rst_rdv", {31'h0, m0_if.readdatavalid}, 32'h0);
        chk("clken", {31'h0, mem_clken}, 32'h1);

        // Simultaneous reads: m0 wins the first tie
        next_cycle();
        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 14'h0020, 32'h0, 4'hF, 1'b0);
        @(negedge clk);
        chk("t1_m0_wait", {31'h0, m0_if.waitrequest}, 32'h0);
        chk("t1_m1_wait", {31'h0, m1_if.waitrequest}, 32'h1);
        chk("t1_addr", {18'h0, mem_address}, 32'h0010);
        push(1'b0, 32'hAAAA0010);
        next_cycle();
        idle(1'b0);
        @(negedge clk);
        chk("t1_m1_wait_c1", {31'h0, m1_if.waitrequest}, 32'h0);
        push(1'b1, 32'hBBBB0020);

        // Both ports request for 8 cycles: strict alternation starting at port 0
        next_cycle();
        drive(1'b0, 1'b1, 1'b0, 14'h0010, 32'h0, 4'hF, 1'b0);
        g0 = 0;
        g1 = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rr_m0_wait", {31'h0, m0_if.waitrequest}, (i % 2 == 1) ? 32'h1 : 32'h0);
            chk("rr_m1_wait", {31'h0, m1_if.waitrequest}, (i % 2 == 0) ? 32'h1 : 32'h0);
            if (!m0_if.waitrequest) begin g0++; push(1'b0, 32'hAAAA0010); end
            if (!m1_if.waitrequest) begin g1++; push(1'b1, 32'hBBBB0020); end
            next_cycle();
        end
        chk("rr_g0", g0, 4);
        chk("rr_g1", g1, 4);
        idle(1'b0);

        // Partial write then read-after-write on m1
        drive(1'b1, 1'b0, 1'b1, 14'h0100, 32'h12345678, 4'b0011, 1'b0);
        @(negedge clk);
        chk("raw_wr_wait", {31'h0, m1_if.waitrequest}, 32'h0);
        chk("raw_mem_write", {31'h0, mem_write}, 32'h1);
        next_cycle();
        drive(1'b1, 1'b1, 1'b0, 14'h0100, 32'h0, 4'hF, 1'b0);
        @(negedge clk);
        chk("raw_rd_wait", {31'h0, m1_if.waitrequest}, 32'h0);
        push(1'b1, 32'hFFFF5678);

        // Lock: m0 read+write @5 while m1 requests throughout
        next_cycle();
        drive(1'b0, 1'b1, 1'b0, 14'h0005, 32'h0, 4'hF, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 14'h0020, 32'h0, 4'hF, 1'b0);
        @(negedge clk);
        chk("lk_c0_m0_wait", {31'h0, m0_if.waitrequest}, 32'h0);
        chk("lk_c0_m1_wait", {31'h0, m1_if.waitrequest}, 32'h1);
        push(1'b0, 32'h55555555);
        next_cycle();
        drive(1'b0, 1'b0, 1'b1, 14'h0005, 32'hCAFEF00D, 4'hF, 1'b0);
        @(negedge clk);
        chk("lk_c1_m0_wait", {31'h0, m0_if.waitrequest}, 32'h0);
        chk("lk_c1_m1_wait", {31'h0, m1_if.waitrequest}, 32'h1);
        chk("lk_c1_mem_write", {31'h0, mem_write}, 32'h1);
        next_cycle();
        idle(1'b0);
        @(negedge clk);
        chk("lk_c2_m1_wait", {31'h0, m1_if.waitrequest}, 32'h0);
        push(1'b1, 32'hBBBB0020);
        chk("lk_mem5", mem[14'h0005], 32'hCAFEF00D);

        // Out-of-range read and write on m1
        next_cycle();
        drive(1'b1, 1'b1, 1'b0, 14'd10024, 32'h0, 4'hF, 1'b0);
        @(negedge clk);
        chk("oor_rd_wait", {31'h0, m1_if.waitrequest}, 32'h0);
        chk("oor_rd_cs", {31'h0, mem_chipselect}, 32'h0);
        push(1'b1, 32'h0);
        next_cycle();
        drive(1'b1, 1'b0, 1'b1, 14'd12000, 32'hDEADBEEF, 4'hF, 1'b0);
        @(negedge clk);
        chk("oor_wr_wait", {31'h0, m1_if.waitrequest}, 32'h0);
        chk("oor_wr_cs", {31'h0, mem_chipselect}, 32'h0);
        chk("oor_wr_mw", {31'h0, mem_write}, 32'h0);
        next_cycle();
        idle(1'b1);
        @(negedge clk);
        chk("oor_mem12000", mem[14'd12000], 32'h0);

        // Reset right after an accepted m0 read drops the response and restores last
        next_cycle();
        drive(1'b0, 1'b1, 1'b0, 14'h0010, 32'h0, 4'hF, 1'b0);
        @(negedge clk);
        chk("rstrd_m0_wait", {31'h0, m0_if.waitrequest}, 32'h0);
        next_cycle();
        reset = 1'b1;
        idle(1'b0);
        @(negedge clk);
        chk("rstrd_rdv", {31'h0, m0_if.readdatavalid}, 32'h0);
        next_cycle();
        reset = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 14'h0010, 32'h0, 4'hF, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 14'h0020, 32'h0, 4'hF, 1'b0);
        @(negedge clk);
        chk("rstrd_tie_m0_wait", {31'h0, m0_if.waitrequest}, 32'h0);
        chk("rstrd_tie_m1_wait", {31'h0, m1_if.waitrequest}, 32'h1);
        push(1'b0, 32'hAAAA0010);
        next_cycle();
        idle(1'b0);
        idle(1'b1);

        repeat (3) @(negedge clk);
        chk("sb_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
